// File: rtl/ysyx_22050039_pkg.sv
// Shared types and defaults for the NPC multi-cycle sequencer.
// The optional handshake watchdog is enabled by YSYX_22050039_HS_TIMEOUT_EN.
package ysyx_22050039_pkg;

  localparam int unsigned XLEN_DEF    = 64;
  localparam int unsigned RET_W       = 64;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned CAUSE_W     = 2;
  localparam int unsigned TIMEOUT_DEF = 255;

  localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    EXEC  = 3'd1,
    MEM   = 3'd2,
    WB    = 3'd3,
    HALT  = 3'd4,
    TRAP  = 3'd5
  } state_e;

  typedef logic [CAUSE_W-1:0] cause_t;

  localparam cause_t CAUSE_NONE     = 2'd0;
  localparam cause_t CAUSE_INVAL    = 2'd1;
  localparam cause_t CAUSE_MISALIGN = 2'd2;
  localparam cause_t CAUSE_TIMEOUT  = 2'd3;

  // Sticky terminal status reported to the outside world.
  typedef struct packed {
    logic   halted;
    logic   trapped;
    cause_t cause;
  } status_t;

  // Instruction targets must be word aligned.
  function automatic logic pc_misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_22050039_seq_ctrl_hs_wdog.sv
// Handshake wait counter: expires after TIMEOUT enabled cycles without a clear.
// Only built when YSYX_22050039_HS_TIMEOUT_EN is defined.
`ifdef YSYX_22050039_HS_TIMEOUT_EN
module ysyx_22050039_hs_wdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_c_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Expiry is flagged during the TIMEOUT-th waiting cycle so the caller can act at its end.
  assign expire_c_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_c_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/ysyx_22050039_seq_ctrl.sv
// Multi-cycle instruction sequencer: owns the PC and walks FETCH/EXEC/MEM/WB.
// Define YSYX_22050039_HS_TIMEOUT_EN to trap on handshakes that wait TIMEOUT cycles.
module ysyx_22050039_seq_ctrl
  import ysyx_22050039_pkg::*;
#(
  parameter int unsigned      XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF)
`ifdef YSYX_22050039_HS_TIMEOUT_EN
  ,
  parameter int unsigned      TIMEOUT  = TIMEOUT_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [XLEN-1:0]   pc_o,
  output logic              if_req_o,
  input  logic              if_ack_i,
  input  logic [INST_W-1:0] if_inst_i,
  output logic [INST_W-1:0] inst_o,
  input  logic              is_mem_i,
  input  logic              is_ebreak_i,
  input  logic              is_inval_i,
  input  logic              rf_wen_dec_i,
  input  logic              jump_i,
  input  logic [XLEN-1:0]   dnpc_i,
  output logic              mem_req_o,
  input  logic              mem_ack_i,
  output logic              rf_wen_o,
  output logic              halted_o,
  output logic              trapped_o,
  output logic [CAUSE_W-1:0] trap_cause_o,
  output logic [RET_W-1:0]  retired_o
);

  state_e              state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [XLEN-1:0]     npc_q, npc_d;
  logic [XLEN-1:0]     npc_c;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [RET_W-1:0]    retired_q, retired_d;
  status_t             status_q, status_d;
  logic                if_req_q, if_req_d;
  logic                mem_req_q, mem_req_d;
  logic                rf_wen_q, rf_wen_d;
  logic                wdog_expire_c;

`ifdef YSYX_22050039_HS_TIMEOUT_EN
  logic wdog_clr_c;
  logic wdog_en_c;

  // Any state change (including an ack completing) restarts the wait count.
  assign wdog_clr_c = (state_d != state_q);
  assign wdog_en_c  = (state_q == FETCH) || (state_q == MEM);

  ysyx_22050039_hs_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_hs_wdog (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (wdog_clr_c),
    .en_i       (wdog_en_c),
    .expire_c_o (wdog_expire_c)
  );
`else
  assign wdog_expire_c = 1'b0;
`endif

  assign npc_c = jump_i ? dnpc_i : pc_q + XLEN'(4);

  // Next-state and datapath update; acks are only looked at in their own state.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    npc_d     = npc_q;
    inst_d    = inst_q;
    retired_d = retired_q;
    status_d  = status_q;
    rf_wen_d  = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (if_ack_i) begin
          inst_d  = if_inst_i;
          state_d = EXEC;
        end else if (wdog_expire_c) begin
          status_d.cause = CAUSE_TIMEOUT;
          state_d        = TRAP;
        end
      end
      EXEC: begin
        if (is_inval_i) begin
          status_d.cause = CAUSE_INVAL;
          state_d        = TRAP;
        end else if (is_ebreak_i) begin
          retired_d = retired_q + RET_W'(1);
          state_d   = HALT;
        end else begin
          npc_d = npc_c;
          if (pc_misaligned(npc_c[1:0])) begin
            status_d.cause = CAUSE_MISALIGN;
            state_d        = TRAP;
          end else if (is_mem_i) begin
            state_d = MEM;
          end else begin
            rf_wen_d = rf_wen_dec_i;
            state_d  = WB;
          end
        end
      end
      MEM: begin
        if (mem_ack_i) begin
          rf_wen_d = rf_wen_dec_i;
          state_d  = WB;
        end else if (wdog_expire_c) begin
          status_d.cause = CAUSE_TIMEOUT;
          state_d        = TRAP;
        end
      end
      WB: begin
        pc_d      = npc_q;
        retired_d = retired_q + RET_W'(1);
        state_d   = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    status_d.halted  = (state_d == HALT);
    status_d.trapped = (state_d == TRAP);
    if_req_d         = (state_d == FETCH);
    mem_req_d        = (state_d == MEM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      npc_q     <= RESET_PC;
      inst_q    <= '0;
      retired_q <= '0;
      status_q  <= '0;
      if_req_q  <= 1'b0;
      mem_req_q <= 1'b0;
      rf_wen_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      npc_q     <= npc_d;
      inst_q    <= inst_d;
      retired_q <= retired_d;
      status_q  <= status_d;
      if_req_q  <= if_req_d;
      mem_req_q <= mem_req_d;
      rf_wen_q  <= rf_wen_d;
    end
  end

  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign retired_o    = retired_q;
  assign if_req_o     = if_req_q;
  assign mem_req_o    = mem_req_q;
  assign rf_wen_o     = rf_wen_q;
  assign halted_o     = status_q.halted;
  assign trapped_o    = status_q.trapped;
  assign trap_cause_o = status_q.cause;

endmodule

// File: tb/tb_ysyx_22050039_seq_ctrl.sv
// Randomized instruction-level bench for ysyx_22050039_seq_ctrl; timeout cases
// are added when YSYX_22050039_HS_TIMEOUT_EN is defined.
module tb_ysyx_22050039_seq_ctrl;
  import ysyx_22050039_pkg::*;

`ifdef YSYX_22050039_HS_TIMEOUT_EN
  localparam int unsigned TMO  = 4;
  localparam int unsigned MAXW = 3;
`else
  localparam int unsigned MAXW = 5;
`endif

  localparam int K_ALU = 0, K_MEM = 1, K_JMP = 2, K_EBRK = 3, K_INV = 4, K_TMO = 5;

  logic        clk, rst_n;
  logic [63:0] pc_o, dnpc_i;
  logic        if_req_o, if_ack_i, mem_req_o, mem_ack_i, rf_wen_o;
  logic [31:0] if_inst_i, inst_o;
  logic        is_mem_i, is_ebreak_i, is_inval_i, rf_wen_dec_i, jump_i;
  logic        halted_o, trapped_o;
  logic [1:0]  trap_cause_o;
  logic [63:0] retired_o;

`ifdef YSYX_22050039_HS_TIMEOUT_EN
  ysyx_22050039_seq_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .pc_o(pc_o), .if_req_o(if_req_o), .if_ack_i(if_ack_i),
    .if_inst_i(if_inst_i), .inst_o(inst_o), .is_mem_i(is_mem_i), .is_ebreak_i(is_ebreak_i),
    .is_inval_i(is_inval_i), .rf_wen_dec_i(rf_wen_dec_i), .jump_i(jump_i), .dnpc_i(dnpc_i),
    .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i), .rf_wen_o(rf_wen_o), .halted_o(halted_o),
    .trapped_o(trapped_o), .trap_cause_o(trap_cause_o), .retired_o(retired_o)
  );
`else
  ysyx_22050039_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pc_o(pc_o), .if_req_o(if_req_o), .if_ack_i(if_ack_i),
    .if_inst_i(if_inst_i), .inst_o(inst_o), .is_mem_i(is_mem_i), .is_ebreak_i(is_ebreak_i),
    .is_inval_i(is_inval_i), .rf_wen_dec_i(rf_wen_dec_i), .jump_i(jump_i), .dnpc_i(dnpc_i),
    .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i), .rf_wen_o(rf_wen_o), .halted_o(halted_o),
    .trapped_o(trapped_o), .trap_cause_o(trap_cause_o), .retired_o(retired_o)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [63:0] m_pc;
  logic [63:0] m_ret;
  bit          fresh;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Architectural view expected for the current cycle.
  task automatic exp_cycle(input string tag, input logic e_if, input logic e_mem,
                           input logic e_wen, input logic e_halt, input logic e_trap,
                           input logic [1:0] e_cause);
    chk({tag, ".pc"}, pc_o, m_pc);
    chk({tag, ".retired"}, retired_o, m_ret);
    chk({tag, ".if_req"}, 64'(if_req_o), 64'(e_if));
    chk({tag, ".mem_req"}, 64'(mem_req_o), 64'(e_mem));
    chk({tag, ".rf_wen"}, 64'(rf_wen_o), 64'(e_wen));
    chk({tag, ".halted"}, 64'(halted_o), 64'(e_halt));
    chk({tag, ".trapped"}, 64'(trapped_o), 64'(e_trap));
    chk({tag, ".cause"}, 64'(trap_cause_o), 64'(e_cause));
  endtask

  task automatic reset_tail();
    @(posedge clk);
    #2;
    exp_cycle("rst_hold", 0, 0, 0, 0, 0, 0);
    rst_n   = 1'b1;
    if_ack_i = 1'b0;
    fresh   = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    if_ack_i = 1'b0;
    mem_ack_i = 1'b0;
    #1;
    m_pc  = RESET_PC_DEF;
    m_ret = '0;
    exp_cycle("rst", 0, 0, 0, 0, 0, 0);
    chk("rst.inst", 64'(inst_o), 64'd0);
    reset_tail();
  endtask

  task automatic terminal(input string tag, input logic h, input logic t, input logic [1:0] c);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if_ack_i  = 1'($urandom_range(0, 1));
      mem_ack_i = 1'($urandom_range(0, 1));
      exp_cycle(tag, 0, 0, 0, h, t, c);
    end
    apply_reset();
  endtask

  // One instruction end to end: fetch waits, exec, optional mem waits, writeback.
  task automatic run_instr(input int kind, input int wf, input int wm,
                           input logic [63:0] tgt, input logic wen, input bit abort);
    logic [31:0] iw;
    logic [63:0] npc;
    iw           = $urandom;
    is_mem_i     = (kind == K_MEM);
    is_ebreak_i  = (kind == K_EBRK);
    is_inval_i   = (kind == K_INV);
    rf_wen_dec_i = wen;
    jump_i       = (kind == K_JMP) || (kind == K_EBRK) || (kind == K_INV);
    dnpc_i       = tgt;
`ifdef YSYX_22050039_HS_TIMEOUT_EN
    if (kind == K_TMO) begin
      for (int i = 0; i < int'(TMO); i++) begin
        @(negedge clk);
        if_ack_i  = 1'b0;
        mem_ack_i = 1'($urandom_range(0, 1));
        exp_cycle("tmo_fetch", !(fresh && i == 0), 0, 0, 0, 0, 0);
      end
      fresh = 1'b0;
      terminal("tmo_trap", 0, 1, 2'd3);
      return;
    end
`endif
    for (int i = 0; i <= wf; i++) begin
      @(negedge clk);
      if_ack_i  = (i == wf);
      if_inst_i = (i == wf) ? iw : 32'($urandom);
      mem_ack_i = 1'($urandom_range(0, 1));
      exp_cycle("fetch", !(fresh && i == 0), 0, 0, 0, 0, 0);
    end
    fresh = 1'b0;
    @(negedge clk);
    if_ack_i  = 1'($urandom_range(0, 1));
    mem_ack_i = 1'($urandom_range(0, 1));
    exp_cycle("exec", 0, 0, 0, 0, 0, 0);
    chk("exec.inst", 64'(inst_o), 64'(iw));
    if (kind == K_INV) begin
      terminal("inval", 0, 1, 2'd1);
      return;
    end
    if (kind == K_EBRK) begin
      m_ret = m_ret + 64'd1;
      terminal("ebreak", 1, 0, 2'd0);
      return;
    end
    npc = (kind == K_JMP) ? tgt : m_pc + 64'd4;
    if (npc[1:0] != 2'b00) begin
      terminal("misalign", 0, 1, 2'd2);
      return;
    end
    if (kind == K_MEM) begin
      for (int j = 0; j <= wm; j++) begin
        @(negedge clk);
        mem_ack_i = (j == wm);
        if_ack_i  = 1'($urandom_range(0, 1));
        exp_cycle("mem", 0, 1, 0, 0, 0, 0);
        if (abort) begin
          #2;
          rst_n = 1'b0;
          #1;
          m_pc  = RESET_PC_DEF;
          m_ret = '0;
          exp_cycle("rst_mem", 0, 0, 0, 0, 0, 0);
          chk("rst_mem.inst", 64'(inst_o), 64'd0);
          reset_tail();
          return;
        end
      end
    end
    @(negedge clk);
    if_ack_i  = 1'($urandom_range(0, 1));
    mem_ack_i = 1'($urandom_range(0, 1));
    exp_cycle("wb", 0, 0, wen, 0, 0, 0);
    m_pc  = npc;
    m_ret = m_ret + 64'd1;
  endtask

  initial begin
    int r, kind;
    logic [63:0] tgt;
    rst_n = 1'b1; if_ack_i = 1'b0; mem_ack_i = 1'b0; if_inst_i = '0;
    is_mem_i = 1'b0; is_ebreak_i = 1'b0; is_inval_i = 1'b0; rf_wen_dec_i = 1'b0;
    jump_i = 1'b0; dnpc_i = '0; m_pc = RESET_PC_DEF; m_ret = '0; fresh = 1'b1;
    apply_reset();

    // Back-to-back ALU ops with immediate acks: 3 cycles each.
    for (int i = 0; i < 3; i++) run_instr(K_ALU, 0, 0, 64'h0, 1'b1, 0);
    @(negedge clk);
    chk("addi3.retired", retired_o, 64'd3);
    chk("addi3.pc", pc_o, 64'h8000_000C);
    run_instr(K_JMP, 0, 0, 64'h8000_0100, 1'b1, 0);
    run_instr(K_ALU, 1, 0, 64'h0, 1'b0, 0);
    run_instr(K_JMP, 0, 0, 64'h8000_0102, 1'b1, 0);
    run_instr(K_MEM, 0, 2, 64'h0, 1'b1, 0);
    run_instr(K_INV, 0, 0, 64'h3, 1'b1, 0);
    run_instr(K_ALU, 0, 0, 64'h0, 1'b1, 0);
    run_instr(K_EBRK, 0, 0, 64'h1, 1'b1, 0);
    run_instr(K_MEM, 1, 3, 64'h0, 1'b1, 1);
    run_instr(K_JMP, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 0);
    run_instr(K_ALU, 0, 0, 64'h0, 1'b1, 0);
`ifdef YSYX_22050039_HS_TIMEOUT_EN
    apply_reset();
    run_instr(K_TMO, 0, 0, 64'h0, 1'b0, 0);
    run_instr(K_ALU, 3, 0, 64'h0, 1'b1, 0);
    run_instr(K_MEM, 3, 3, 64'h0, 1'b1, 0);
`endif

    for (int n = 0; n < 200; n++) begin
      r   = int'($urandom_range(0, 99));
      tgt = {32'($urandom), 32'($urandom)};
      if (r < 40) kind = K_ALU;
      else if (r < 65) kind = K_MEM;
      else if (r < 85) kind = K_JMP;
      else if (r < 90) kind = K_EBRK;
      else if (r < 95) kind = K_INV;
`ifdef YSYX_22050039_HS_TIMEOUT_EN
      else kind = K_TMO;
`else
      else kind = K_ALU;
`endif
      if (kind == K_JMP && $urandom_range(0, 9) != 0) tgt[1:0] = 2'b00;
      run_instr(kind, int'($urandom_range(0, MAXW)), int'($urandom_range(0, MAXW)), tgt,
                1'($urandom_range(0, 1)), (kind == K_MEM) && ($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22050039_seq_ctrl.md
# ysyx_22050039_seq_ctrl

Multi-cycle instruction sequencer for the NPC core. It owns the PC and steps each instruction through fetch, execute, optional memory access and writeback. It handshakes with instruction and data memory, and gates register-file writes. It converts the decoder's ebreak and invalid-instruction flags into sticky halt/trap state, replacing the free-running single-cycle datapath with an explicit state machine.

## Interface
- XLEN, 64, datapath width
- RESET_PC, 64'h8000_0000, PC value after reset
- TIMEOUT, 255, maximum wait cycles on a handshake (used only with the macro below)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- pc  out  XLEN  current instruction PC
- if_req  out  1  instruction fetch request
- if_ack  in  1  fetch data valid this cycle
- if_inst  in  32  fetched instruction
- inst  out  32  latched instruction, feeds decoder
- is_mem  in  1  decoded load/store
- is_ebreak  in  1  decoded ebreak
- is_inval  in  1  decoded invalid instruction
- rf_wen_dec  in  1  decoder register-write enable
- jump  in  1  EXU redirect, take dnpc
- dnpc  in  XLEN  EXU target PC
- mem_req  out  1  data memory request
- mem_ack  in  1  data access complete
- rf_wen  out  1  register-file write strobe
- halted  out  1  sticky, ebreak retired
- trapped  out  1  sticky, fault taken
- trap_cause  out  2  0 none, 1 invalid, 2 misaligned target, 3 timeout
- retired  out  64  retired instruction count

## Operation
- Reset values: pc=RESET_PC, inst=0, if_req=0, mem_req=0, rf_wen=0, halted=0, trapped=0, trap_cause=0, retired=0, state=FETCH. All apply immediately on rst low, including mid-instruction; any outstanding handshake is abandoned.
- FETCH: if_req=1. If if_ack=1, latch if_inst into inst and go to EXEC. If if_ack=0, stay.
- EXEC: evaluate in priority order.
  - is_inval: go to TRAP, cause 1.
  - is_ebreak: retired+1, go to HALT.
  - Otherwise latch npc = jump ? dnpc : pc+4.
  - npc[1:0]!=0: go to TRAP, cause 2.
  - is_mem: go to MEM.
  - Otherwise go to WB.
- MEM: mem_req=1 until mem_ack, then go to WB.
- WB: rf_wen=rf_wen_dec for exactly this cycle; pc<=npc; retired+1; go to FETCH.
- HALT: halted=1. Terminal until reset; no requests issued.
- TRAP: trapped=1, trap_cause held. Terminal until reset; pc holds the faulting instruction's PC.
- if_ack outside FETCH and mem_ack outside MEM are ignored.
- pc+4 and the retired count wrap modulo 2^XLEN and 2^64 respectively.
- rf_wen never asserts outside WB.

## Timing
- if_req, mem_req and rf_wen are registered state decodes; no combinational path from input to output.
- An ack sampled in the same cycle as its request completes the handshake.
- Minimum latency: ALU/branch instruction 3 cycles (FETCH, EXEC, WB); memory instruction 4 cycles; each ack-wait cycle adds 1.
- pc and retired update at the end of WB; the new pc is visible in the following FETCH cycle.
- halted/trapped rise at the clock edge that leaves EXEC.

## Configuration
- YSYX_22050039_HS_TIMEOUT_EN defined: a wait counter runs in FETCH and MEM.
  - Cleared on state entry and on ack.
  - Reaching TIMEOUT cycles without ack forces TRAP with cause 3.
  - An ack arriving in the expiry cycle wins.
- Undefined: handshakes wait indefinitely; cause 3 is never produced and the counter is not instantiated.

## Structure
- Package ysyx_22050039_pkg holds:
  - state enum (FETCH, EXEC, MEM, WB, HALT, TRAP)
  - trap cause constants
  - RESET_PC default
- One sub-module, ysyx_22050039_hs_wdog: the handshake timeout counter (clear, enable, expire), instantiated only under the macro.

## Test plan
- Reset release, if_ack tied 1, addi stream: pc advances 8000_0000, 8000_0004, 8000_0008 every 3 cycles; rf_wen one-cycle pulse each WB; retired=3 after 9 cycles.
- Load with mem_ack delayed 2 cycles: mem_req high for 3 cycles; instruction retires in 6 cycles; rf_wen pulses once.
- jal with jump=1, dnpc=8000_0100: next if_req issued with pc=8000_0100. Same case with dnpc=8000_0102: trapped=1, trap_cause=2, pc unchanged.
- is_inval in EXEC: trapped=1, cause 1, retired unchanged, no further if_req. is_ebreak: halted=1, retired+1.
- rst pulsed low during MEM wait: mem_req drops immediately; pc=8000_0000 and FETCH on release.
- Macro on, TIMEOUT=4, if_ack held 0: trap cause 3 after 4 FETCH cycles. Ack on the 4th cycle: no trap, proceeds to EXEC.
